// File: rtl/au_result_router.sv
// ---------------------------------------------------------------------------
// au_result_router
//   Return path from the arithmetic unit to its NUM_DEST destination write
//   ports. Each accepted AU result is tagged with a destination index and
//   buffered in a small circular FIFO. The head entry is presented on a
//   shared data bus with a one-hot valid that selects the single consumer.
//   Results leave strictly in arrival order; a stalled head blocks the queue.
//   Entries whose index is out of range are drained silently and latch a
//   sticky error flag.
//
// Ports:
//   CLK         clock, rising-edge
//   RST_N       asynchronous active-low reset
//   DIN         AU result
//   DEST        destination index for DIN
//   DIN_VALID   DIN/DEST valid
//   DIN_READY   router can accept this cycle (registered)
//   DOUT        head result, broadcast to all destinations (registered)
//   DOUT_VALID  one-hot valid, bit = head destination (registered)
//   DOUT_READY  per-destination ready
//   ERR_STICKY  set when an out-of-range destination entry is drained
//   CLR_ERR     synchronous clear of ERR_STICKY (and perf counters)
//   FILL        current FIFO occupancy (registered)
//   DELIV_CNT   completed deliveries      (AU_ROUTER_PERF_CNT_EN only)
//   STALL_CNT   head-blocked cycles       (AU_ROUTER_PERF_CNT_EN only)
//
// Build option:
//   AU_ROUTER_PERF_CNT_EN  adds the DELIV_CNT / STALL_CNT counters.
// ---------------------------------------------------------------------------
module au_result_router #(
  parameter int unsigned NUM_DEST = 21,
  parameter int unsigned SEL_W    = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [DATA_W-1:0]       DIN,
  input  logic [SEL_W-1:0]        DEST,
  input  logic                    DIN_VALID,
  output logic                    DIN_READY,
  output logic [DATA_W-1:0]       DOUT,
  output logic [NUM_DEST-1:0]     DOUT_VALID,
  input  logic [NUM_DEST-1:0]     DOUT_READY,
  output logic                    ERR_STICKY,
  input  logic                    CLR_ERR,
  output logic [$clog2(DEPTH):0]  FILL
`ifdef AU_ROUTER_PERF_CNT_EN
  ,
  output logic [31:0]             DELIV_CNT,
  output logic [31:0]             STALL_CNT
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned ENT_W = SEL_W + DATA_W;

  // FIFO storage: each entry is {dest, data}
  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [ENT_W-1:0]    mem_d [DEPTH];

  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    fill_q, fill_d;
  logic                din_ready_q, din_ready_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [NUM_DEST-1:0] dout_valid_q, dout_valid_d;
  logic                err_q, err_d;

  // Head decode and handshake
  logic [ENT_W-1:0]    head_ent;
  logic [SEL_W-1:0]    head_dest;
  logic                head_in_range;
  logic                head_ready;
  logic                not_empty;
  logic                push;
  logic                pop;
  logic                deliver;
  logic                err_set;
  logic                stall;

  // Next-head lookahead used to register DOUT / DOUT_VALID
  logic [ENT_W-1:0]    nxt_ent;
  logic [SEL_W-1:0]    nxt_dest;
  logic                nxt_in_range;

  // Current head and transfer qualification
  always_comb begin
    head_ent      = mem_q[rd_ptr_q[IDX_W-1:0]];
    head_dest     = head_ent[ENT_W-1:DATA_W];
    head_in_range = (32'(head_dest) < NUM_DEST);
    head_ready    = 1'b0;
    // Only the ready bit of the head destination matters
    for (int unsigned i = 0; i < NUM_DEST; i++) begin
      if (32'(head_dest) == i) begin
        head_ready = DOUT_READY[i];
      end
    end
    not_empty = (fill_q != '0);
    push      = DIN_VALID & din_ready_q;
    // Out-of-range heads drain unconditionally
    pop       = not_empty & (~head_in_range | head_ready);
    deliver   = pop & head_in_range;
    err_set   = pop & ~head_in_range;
    stall     = not_empty & head_in_range & ~head_ready;
  end

  // Pointer, storage, occupancy and output next-state
  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    dout_d       = dout_q;
    dout_valid_d = '0;
    err_d        = err_q;

    if (push) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = {DEST, DIN};
    end

    fill_d      = wr_ptr_d - rd_ptr_d;
    // Ready follows next occupancy, so a pop on a full FIFO frees a slot
    // only from the following cycle on
    din_ready_d = (fill_d != PTR_W'(DEPTH));

    // Present the post-edge head; a fresh push into an empty FIFO is
    // visible the cycle after it was accepted
    nxt_ent      = mem_d[rd_ptr_d[IDX_W-1:0]];
    nxt_dest     = nxt_ent[ENT_W-1:DATA_W];
    nxt_in_range = (32'(nxt_dest) < NUM_DEST);
    if ((fill_d != '0) && nxt_in_range) begin
      dout_d = nxt_ent[DATA_W-1:0];
      for (int unsigned i = 0; i < NUM_DEST; i++) begin
        dout_valid_d[i] = (32'(nxt_dest) == i);
      end
    end

    // Set has priority over clear
    if (err_set) begin
      err_d = 1'b1;
    end else if (CLR_ERR) begin
      err_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      din_ready_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= '0;
      err_q        <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      din_ready_q  <= din_ready_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
    end
  end

  assign DIN_READY  = din_ready_q;
  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign ERR_STICKY = err_q;
  assign FILL       = fill_q;

`ifdef AU_ROUTER_PERF_CNT_EN
  logic [31:0] deliv_cnt_q, deliv_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Delivery / stall counters, wrapping, cleared together with the error flag
  always_comb begin
    deliv_cnt_d = deliv_cnt_q + 32'(deliver);
    stall_cnt_d = stall_cnt_q + 32'(stall);
    if (CLR_ERR) begin
      deliv_cnt_d = '0;
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deliv_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      deliv_cnt_q <= deliv_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign DELIV_CNT = deliv_cnt_q;
  assign STALL_CNT = stall_cnt_q;
`else
  // Without performance counters the delivery and stall strobes are unused
  logic unused_perf;
  assign unused_perf = deliver ^ stall;
`endif

endmodule

// File: tb/tb_au_result_router.sv
// ---------------------------------------------------------------------------
// tb_au_result_router
//   Directed self-checking bench for au_result_router with default
//   parameters (21 destinations, 32-bit data, 4-entry FIFO).
//   Inputs change #1 after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_au_result_router;

  localparam int unsigned NUM_DEST = 21;
  localparam int unsigned SEL_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DEPTH    = 4;

  logic                    CLK;
  logic                    RST_N;
  logic [DATA_W-1:0]       DIN;
  logic [SEL_W-1:0]        DEST;
  logic                    DIN_VALID;
  logic                    DIN_READY;
  logic [DATA_W-1:0]       DOUT;
  logic [NUM_DEST-1:0]     DOUT_VALID;
  logic [NUM_DEST-1:0]     DOUT_READY;
  logic                    ERR_STICKY;
  logic                    CLR_ERR;
  logic [$clog2(DEPTH):0]  FILL;
`ifdef AU_ROUTER_PERF_CNT_EN
  logic [31:0]             DELIV_CNT;
  logic [31:0]             STALL_CNT;
`endif

  int n_tests;
  int n_fail;

  au_result_router #(
    .NUM_DEST (NUM_DEST),
    .SEL_W    (SEL_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .DIN        (DIN),
    .DEST       (DEST),
    .DIN_VALID  (DIN_VALID),
    .DIN_READY  (DIN_READY),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .ERR_STICKY (ERR_STICKY),
    .CLR_ERR    (CLR_ERR),
    .FILL       (FILL)
`ifdef AU_ROUTER_PERF_CNT_EN
    ,
    .DELIV_CNT  (DELIV_CNT),
    .STALL_CNT  (STALL_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    RST_N      = 1'b0;
    DIN        = '0;
    DEST       = '0;
    DIN_VALID  = 1'b0;
    DOUT_READY = '0;
    CLR_ERR    = 1'b0;

    // Reset state
    #2;
    chk("rst_fill",  64'(FILL), 64'd0);
    chk("rst_ready", 64'(DIN_READY), 64'd0);
    chk("rst_vld",   64'(DOUT_VALID), 64'd0);
    chk("rst_dout",  64'(DOUT), 64'd0);
    chk("rst_err",   64'(ERR_STICKY), 64'd0);
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    chk("ready_after_rst", 64'(DIN_READY), 64'd1);

    // Single route to destination 7
    DOUT_READY = '1;
    DIN_VALID  = 1'b1;
    DEST       = 5'd7;
    DIN        = 32'hDEADBEEF;
    tick();
    DIN_VALID  = 1'b0;
    chk("single_vld",  64'(DOUT_VALID), 64'h000080);
    chk("single_dout", 64'(DOUT), 64'hDEADBEEF);
    chk("single_fill", 64'(FILL), 64'd1);
    tick();
    chk("single_vld_done",  64'(DOUT_VALID), 64'd0);
    chk("single_fill_done", 64'(FILL), 64'd0);
    chk("single_dout_hold", 64'(DOUT), 64'hDEADBEEF);

    // Back-pressure on destination 3 until full; the fifth push is refused
    DOUT_READY = 21'h1FFFF7;
    for (int i = 0; i < 5; i++) begin
      DIN_VALID = 1'b1;
      DEST      = 5'd3;
      DIN       = 32'h100 + 32'(i);
      tick();
    end
    DIN_VALID = 1'b0;
    chk("full_fill",  64'(FILL), 64'd4);
    chk("full_ready", 64'(DIN_READY), 64'd0);
    chk("full_vld",   64'(DOUT_VALID), 64'h8);
    chk("full_dout",  64'(DOUT), 64'h100);
    DOUT_READY = '1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_dout", 64'(DOUT), 64'h100 + 64'(k));
      chk("drain_vld",  64'(DOUT_VALID), 64'h8);
      tick();
    end
    chk("drain_fill",  64'(FILL), 64'd0);
    chk("drain_vld0",  64'(DOUT_VALID), 64'd0);
    chk("drain_ready", 64'(DIN_READY), 64'd1);
    chk("drain_last",  64'(DOUT), 64'h103);

    // Wrong-ready isolation on destination 20
    DOUT_READY = 21'h0FFFFF;
    DIN_VALID  = 1'b1;
    DEST       = 5'd20;
    DIN        = 32'hA5A50020;
    tick();
    DIN_VALID  = 1'b0;
    tick();
    tick();
    tick();
    chk("iso_vld",  64'(DOUT_VALID), 64'h100000);
    chk("iso_dout", 64'(DOUT), 64'hA5A50020);
    chk("iso_fill", 64'(FILL), 64'd1);
    DOUT_READY = 21'h1FFFFF;
    tick();
    chk("iso_pop_fill", 64'(FILL), 64'd0);
    chk("iso_pop_vld",  64'(DOUT_VALID), 64'd0);

    // Out-of-range destination followed by a valid one
    DOUT_READY = '1;
    DIN_VALID  = 1'b1;
    DEST       = 5'd25;
    DIN        = 32'h00000BAD;
    tick();
    DEST       = 5'd2;
    DIN        = 32'h00000022;
    chk("bad_head_vld",  64'(DOUT_VALID), 64'd0);
    chk("bad_head_err",  64'(ERR_STICKY), 64'd0);
    chk("bad_head_fill", 64'(FILL), 64'd1);
    tick();
    DIN_VALID  = 1'b0;
    chk("bad_err_set", 64'(ERR_STICKY), 64'd1);
    chk("bad_next_vld",  64'(DOUT_VALID), 64'h4);
    chk("bad_next_dout", 64'(DOUT), 64'h22);
    chk("bad_next_fill", 64'(FILL), 64'd1);
    tick();
    chk("bad_drained", 64'(FILL), 64'd0);
    chk("bad_err_hold", 64'(ERR_STICKY), 64'd1);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("err_clear", 64'(ERR_STICKY), 64'd0);

    // Set and clear in the same cycle: set wins
    DIN_VALID = 1'b1;
    DEST      = 5'd31;
    DIN       = 32'h31;
    tick();
    DIN_VALID = 1'b0;
    CLR_ERR   = 1'b1;
    tick();
    CLR_ERR   = 1'b0;
    chk("set_wins", 64'(ERR_STICKY), 64'd1);
    chk("set_wins_fill", 64'(FILL), 64'd0);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("err_clear2", 64'(ERR_STICKY), 64'd0);

    // Streaming with rotating destinations, pointers wrap twice
    DOUT_READY = '1;
    for (int i = 0; i < 10; i++) begin
      DIN_VALID = 1'b1;
      DEST      = 5'(i);
      DIN       = 32'h5000 + 32'(i);
      tick();
      chk("stream_dout",  64'(DOUT), 64'h5000 + 64'(i));
      chk("stream_vld",   64'(DOUT_VALID), 64'd1 << i);
      chk("stream_fill",  64'(FILL), 64'd1);
      chk("stream_ready", 64'(DIN_READY), 64'd1);
    end
    DIN_VALID = 1'b0;
    tick();
    chk("stream_end_fill", 64'(FILL), 64'd0);
    chk("stream_end_vld",  64'(DOUT_VALID), 64'd0);
`ifdef AU_ROUTER_PERF_CNT_EN
    chk("deliv_cnt", 64'(DELIV_CNT), 64'd10);
    chk("stall_cnt", 64'(STALL_CNT), 64'd0);
`endif

    // Reset mid-stream discards buffered entries immediately
    DOUT_READY = '0;
    for (int i = 0; i < 3; i++) begin
      DIN_VALID = 1'b1;
      DEST      = 5'd1;
      DIN       = 32'h7000 + 32'(i);
      tick();
    end
    DIN_VALID = 1'b0;
    chk("pre_rst_fill", 64'(FILL), 64'd3);
    chk("pre_rst_vld",  64'(DOUT_VALID), 64'h2);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_fill",  64'(FILL), 64'd0);
    chk("mid_rst_vld",   64'(DOUT_VALID), 64'd0);
    chk("mid_rst_dout",  64'(DOUT), 64'd0);
    chk("mid_rst_ready", 64'(DIN_READY), 64'd0);
    tick();
    RST_N      = 1'b1;
    DOUT_READY = '1;
    tick();
    tick();
    chk("post_rst_fill",  64'(FILL), 64'd0);
    chk("post_rst_vld",   64'(DOUT_VALID), 64'd0);
    chk("post_rst_dout",  64'(DOUT), 64'd0);
    chk("post_rst_ready", 64'(DIN_READY), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
